// File: rtl/demux_tdm_if.sv
// Stream bundle for the TDM demultiplexer: narrow per-slot input beats on
// one side, the reassembled wide frame on the other. The slave modport is
// the demultiplexer's view; master is the view of whatever feeds it beats
// and consumes its frames.
interface demux_tdm_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_sof;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_tdm.sv
// Time-division demultiplexer. Beat k of each frame (slot 0 flagged by
// in_sof) lands in lane k; once all LANES slots are filled the frame is
// presented as one wide word and held until the consumer takes it.
// Optional macro DEMUX_TDM_ERRCNT_EN adds a saturating 8-bit err_count
// output that tallies sync_err pulses.
module demux_tdm #(
    parameter  int LANES = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_tdm_if.slave       bus,
    output logic [SEL_W-1:0] slot,
    output logic             sync_err
`ifdef DEMUX_TDM_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic [SEL_W-1:0]       slot_next;
    logic [SEL_W-1:0]       wr_idx;
    logic                   lane_we;
    logic                   sync_err_next;
    logic [LANES*WIDTH-1:0] lane_q;

    assign accept = bus.in_valid && bus.in_ready;

    // State register; reset drops any partial or held frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a frame starts on sof, completes on the last slot, and
    // leaves HOLD only when the consumer takes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && bus.in_sof) begin
                    state_next = (LANES == 1) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (accept && !bus.in_sof && (slot == LAST_SLOT)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: accept beats outside HOLD, present the frame only in HOLD.
    always_comb begin
        bus.in_ready  = (state != HOLD);
        bus.out_valid = (state == HOLD);
        bus.out_data  = lane_q;
    end

    // Beat routing: pick the lane to write, the next slot index and whether
    // this beat breaks framing (stray non-sof in IDLE, early sof in FILL).
    always_comb begin
        slot_next     = slot;
        wr_idx        = '0;
        lane_we       = 1'b0;
        sync_err_next = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (bus.in_sof) begin
                        lane_we   = 1'b1;
                        slot_next = (LANES == 1) ? '0 : SEL_W'(1);
                    end else begin
                        sync_err_next = 1'b1;
                    end
                end
                FILL: begin
                    lane_we = 1'b1;
                    if (bus.in_sof) begin
                        slot_next     = SEL_W'(1);
                        sync_err_next = 1'b1;
                    end else begin
                        wr_idx    = slot;
                        slot_next = (slot == LAST_SLOT) ? '0 : slot + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot counter and the registered framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            sync_err <= 1'b0;
        end else begin
            slot     <= slot_next;
            sync_err <= sync_err_next;
        end
    end

    // Lane storage; only accepted beats touch it, so it is stable in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
        end else if (lane_we) begin
            lane_q[int'(wr_idx)*WIDTH +: WIDTH] <= bus.in_data;
        end
    end

`ifdef DEMUX_TDM_ERRCNT_EN
    // Saturating tally of sync_err pulses; sticks at 255 instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (sync_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_tdm.sv
// Directed bench for demux_tdm (LANES=4, WIDTH=8). Expected frames are
// queued as each test drives its beats and are popped by a monitor when the
// block hands a frame over. Define DEMUX_TDM_ERRCNT_EN to cover err_count.
module tb_demux_tdm;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst_n;
    logic [SEL_W-1:0] slot;
    logic             sync_err;
`ifdef DEMUX_TDM_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    demux_tdm_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    demux_tdm #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .slot     (slot),
        .sync_err (sync_err)
`ifdef DEMUX_TDM_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          sync_pulses = 0;
    int          err_base;
    logic [31:0] exp_q[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1; holds the beat until accepted, returns at posedge+1.
    task automatic applyStimulus(input logic [7:0] data, input logic sof);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_sof   = sof;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cycles with sync_err high.
    always @(negedge clk) begin
        if (rst_n && sync_err) sync_pulses++;
    end

    // Scoreboard: a handshake happens at the next edge, so compare now.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checkOutput("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                checkOutput("frame_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        $display("[TB] reset values");
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_slot", 32'(slot), 32'd0);
        checkOutput("rst_sync_err", 32'(sync_err), 32'd0);
        checkOutput("rst_out_data", bus.out_data, 32'd0);
`ifdef DEMUX_TDM_ERRCNT_EN
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycles(1);

        $display("[TB] basic frame, consumer ready");
        exp_q.push_back(32'h44332211);
        applyStimulus(8'h11, 1'b1);
        checkOutput("slot_after_sof", 32'(slot), 32'd1);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        checkOutput("basic_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("basic_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("basic_slot_wrap", 32'(slot), 32'd0);
        waitCycles(1);
        checkOutput("basic_out_valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("basic_idle_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] frame held by back-pressure");
        bus.out_ready = 1'b0;
        exp_q.push_back(32'h44332211);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.in_sof   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_out_data", bus.out_data, 32'h44332211);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
            waitCycles(1);
        end
        checkOutput("hold_slot", 32'(slot), 32'd0);
        bus.out_ready = 1'b1;
        waitCycles(1);
        checkOutput("post_hold_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post_hold_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("pending_not_taken", 32'(slot), 32'd0);
        exp_q.push_back(32'hA4A3A299);
        waitCycles(1);
        checkOutput("pending_taken", 32'(slot), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        applyStimulus(8'hA2, 1'b0);
        applyStimulus(8'hA3, 1'b0);
        applyStimulus(8'hA4, 1'b0);
        waitCycles(1);

        $display("[TB] stray beats while idle");
        err_base = sync_pulses;
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        waitCycles(1);
        checkOutput("stray_sync_pulses", 32'(sync_pulses - err_base), 32'd2);
        checkOutput("stray_sync_err_low", 32'(sync_err), 32'd0);
        checkOutput("stray_slot", 32'(slot), 32'd0);
        checkOutput("stray_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] premature start of frame");
        err_base = sync_pulses;
        exp_q.push_back(32'h40302010);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h10, 1'b1);
        checkOutput("resync_slot", 32'(slot), 32'd1);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h30, 1'b0);
        applyStimulus(8'h40, 1'b0);
        waitCycles(1);
        checkOutput("resync_sync_pulses", 32'(sync_pulses - err_base), 32'd1);

        $display("[TB] reset while holding a frame");
        bus.out_ready = 1'b0;
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b0);
        checkOutput("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("hold_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("hold_rst_out_data", bus.out_data, 32'd0);
        checkOutput("hold_rst_in_ready", 32'(bus.in_ready), 32'd1);
        waitCycles(1);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        waitCycles(1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h31, 1'b1);
        applyStimulus(8'h32, 1'b0);
        checkOutput("pre_rst_slot", 32'(slot), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_slot", 32'(slot), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(1);
        exp_q.push_back(32'h0D0C0B0A);
        applyStimulus(8'h0A, 1'b1);
        applyStimulus(8'h0B, 1'b0);
        applyStimulus(8'h0C, 1'b0);
        applyStimulus(8'h0D, 1'b0);
        waitCycles(1);

`ifdef DEMUX_TDM_ERRCNT_EN
        $display("[TB] error counter saturation");
        rst_n = 1'b0;
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(1);
        for (int i = 0; i < 10; i++) applyStimulus(8'(i), 1'b0);
        waitCycles(2);
        checkOutput("errcnt_10", 32'(err_count), 32'd10);
        for (int i = 10; i < 300; i++) applyStimulus(8'(i), 1'b0);
        waitCycles(3);
        checkOutput("errcnt_saturated", 32'(err_count), 32'd255);
        rst_n = 1'b0;
        #1;
        checkOutput("errcnt_reset", 32'(err_count), 32'd0);
        waitCycles(1);
        rst_n = 1'b1;
        waitCycles(1);
`endif

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
